i2s_transmitter: RTL
====================

// Module: i2s_transmitter
// PURPOSE
//  I2S bus master transmitter. Partner of the I2S receiver on the same audio link.
//  - Accepts 24-bit stereo sample pairs over a valid/ready handshake.
//  - Generates bclk_o and lrclk_o.
//  - Serialises each sample MSB-first in Philips I2S format: one-BCLK delay after
//    the LRCLK edge, 32-bit slots.
//  - Feeds the DAC/codec, or loops back into i2s_receiver for self-test.
// PARAMETERS
//  BCLK_HALF   13   clk_i cycles per BCLK half-period. 40 MHz/26 gives ~1.538 MHz BCLK.
//  DATA_BITS   24   sample width
//  SLOT_BITS   32   BCLKs per channel slot. Must be >= DATA_BITS+1.
// PORTS
//  clk_i           in   1          system clock (40 MHz)
//  rst_ni          in   1          asynchronous, active-low reset
//  enable_i        in   1          run transmitter; low = idle/abort
//  left_i          in   DATA_BITS  left sample, two's complement
//  right_i         in   DATA_BITS  right sample
//  valid_i         in   1          left_i/right_i valid
//  ready_o         out  1          holding register empty; transfer on valid_i & ready_o
//  bclk_o          out  1          bit clock
//  lrclk_o         out  1          word select: 0 = left, 1 = right
//  audio_data_o    out  1          serial data; changes on BCLK falling edge
//  frame_start_o   out  1          1-clk pulse when a new stereo frame is loaded
//  underrun_o      out  1          1-clk pulse when a frame loads with the holding reg empty
// BEHAVIOUR
//  Reset (async, rst_ni=0):
//  - All outputs 0; ready_o=1 after reset release.
//  - div_cnt=0, bit_cnt=2*SLOT_BITS-1, holding and shift registers cleared.
//  Clock divider:
//  - While enabled, div_cnt counts 0..BCLK_HALF-1.
//  - At terminal count, bclk_o toggles; bclk_o starts low.
//  Falling-edge events: on each clk where bclk_o goes 1->0, in the same cycle:
//  - bit_cnt increments mod 2*SLOT_BITS.
//  - lrclk_o <= bit_cnt_next[msb].
//  - audio_data_o updates.
//  Slot position p = bit_cnt mod SLOT_BITS:
//  - p=0: audio_data_o=0 (I2S delay bit).
//  - p=1..DATA_BITS: audio_data_o = word[DATA_BITS-p].
//  - otherwise: audio_data_o=0.
//  - Receiver samples data on the BCLK rising edge.
//  Frame load (bit_cnt wraps 2*SLOT_BITS-1 -> 0):
//  - Shift register <= holding pair.
//  - hold_full clears; frame_start_o pulses.
//  - If hold_full=0: shift register <= zeros and underrun_o pulses with frame_start_o.
//  Handshake:
//  - ready_o = ~hold_full, registered.
//  - Accept on valid_i & ready_o, then hold_full=1.
//  - Load and accept never coincide, because ready_o=0 whenever hold_full=1.
//  - valid_i with ready_o=0 is ignored; the source holds its data.
//  - Accepting while disabled is allowed, so the first frame can be pre-filled.
//  State machine:
//  - IDLE -> RUN on enable_i=1. First falling edge after 2*BCLK_HALF clks loads the
//    frame and starts the left slot.
//  - RUN -> IDLE on enable_i=0, next clk, even mid-frame. bclk_o/lrclk_o/audio_data_o
//    go to 0, divider and bit_cnt reinitialise, shift register clears.
//  - Holding register and hold_full are retained.
//  Timing:
//  - Latency from accept to MSB on the line is at most one frame plus one BCLK:
//    2*SLOT_BITS*2*BCLK_HALF + 2*BCLK_HALF clks.
//  - Frame period = 2*SLOT_BITS*2*BCLK_HALF = 1664 clks with the defaults.
// STRUCTURE
//  Package i2s_pkg (shared with i2s_receiver):
//  - DATA_BITS, SLOT_BITS, BCLK_HALF defaults.
//  - typedef logic [DATA_BITS-1:0] sample_t.
//  - typedef struct {sample_t l, r;} stereo_t.
//  - typedef enum {IDLE, RUN} i2s_state_e.
//  Sub-module i2s_clk_gen:
//  - Contains the divider and bit_cnt.
//  - Outputs bclk, lrclk, bclk_fall pulse, bclk_rise pulse, slot position, frame_wrap.
//  - Reused by the receiver.
//  Top-level holds the handshake, holding register, shift register and data mux.
// TESTING
//  1 Reset: rst_ni=0 mid-frame -> all outputs 0 immediately, without waiting for a
//    clk edge; after release ready_o=1, bclk_o=0 until enable_i.
//  2 Loopback into i2s_receiver: send L=24'h20F3FF, R=24'h20F3FB, then L=24'h20F3F7,
//    R=24'h800001 -> receiver reports the same four words in order; no underrun_o.
//  3 Timing: measure bclk_o period = 26 clks and lrclk_o period = 1664 clks.
//    MSB appears one BCLK after each lrclk_o edge.
//    audio_data_o is stable across every bclk_o rising edge.
//  4 Underrun: enable with no valid_i -> audio_data_o all zeros, underrun_o pulses
//    once per frame. Supply L=24'hFFFFFF, R=24'h000000 -> next frame carries it,
//    underrun_o stays low.
//  5 Back-pressure: hold valid_i=1 continuously -> ready_o high for exactly 1 clk per
//    frame after frame_start_o; no sample is dropped or duplicated.
//  6 Enable drop mid right slot -> outputs 0 next clk. Re-enable -> the retained
//    holding pair is sent in the first frame, starting in the left slot.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S link definitions: default geometry, sample types and FSM states.
// Used by both the transmitter and the receiver.
package i2s_pkg;

    localparam int unsigned DATA_BITS = 24;
    localparam int unsigned SLOT_BITS = 32;
    localparam int unsigned BCLK_HALF = 13;
    localparam int unsigned IW        = $clog2(DATA_BITS);

    typedef logic [DATA_BITS-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic {
        IDLE,
        RUN
    } i2s_state_e;

    // Bit on the line at slot position p: delay bit, MSB-first data, zero pad.
    function automatic logic slot_bit(input sample_t w, input int unsigned p);
        logic [IW-1:0] idx;
        idx = '0;
        if (p == 0 || p > DATA_BITS) begin
            return 1'b0;
        end
        idx = IW'(DATA_BITS - p);
        return w[idx];
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit/word clock generator: BCLK divider plus frame bit counter.
// Edge strobes and slot position let tx and rx act in the same clk as the edge.
module i2s_clk_gen #(
    parameter int unsigned BCLK_HALF = 13,
    parameter int unsigned SLOT_BITS = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         run_i,
    output logic                         bclk_o,
    output logic                         lrclk_o,
    output logic                         bclk_fall_o,
    output logic                         bclk_rise_o,
    output logic [$clog2(SLOT_BITS)-1:0] slot_pos_o,
    output logic                         slot_chan_o,
    output logic                         frame_wrap_o
);

    localparam int unsigned DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned CW = $clog2(2 * SLOT_BITS);
    localparam int unsigned PW = $clog2(SLOT_BITS);
    localparam logic [CW-1:0] LAST = CW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] HALF = CW'(SLOT_BITS);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] bit_q, bit_d, bit_inc;
    logic          bclk_q, bclk_d;
    logic          lr_q, lr_d;
    logic          tc, chan;

    always_comb begin
        tc           = (div_q == DW'(BCLK_HALF - 1));
        bclk_fall_o  = run_i & tc & bclk_q;
        bclk_rise_o  = run_i & tc & ~bclk_q;
        frame_wrap_o = bclk_fall_o & (bit_q == LAST);
        bit_inc      = (bit_q == LAST) ? '0 : bit_q + 1'b1;
        chan         = (bit_inc >= HALF);
        slot_chan_o  = chan;
        slot_pos_o   = PW'(chan ? bit_inc - HALF : bit_inc);
        div_d        = tc ? '0 : div_q + 1'b1;
        bclk_d       = bclk_q ^ tc;
        bit_d        = bclk_fall_o ? bit_inc : bit_q;
        lr_d         = bclk_fall_o ? chan : lr_q;
        if (!run_i) begin
            div_d  = '0;
            bclk_d = 1'b0;
            bit_d  = LAST;
            lr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            bit_q  <= LAST;
            lr_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            bit_q  <= bit_d;
            lr_q   <= lr_d;
        end
    end

    assign bclk_o  = bclk_q;
    assign lrclk_o = lr_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S bus master transmitter: valid/ready sample intake, one-deep holding
// register, per-frame load and Philips-format serialisation.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_HALF = i2s_pkg::BCLK_HALF,
    parameter int unsigned SLOT_BITS = i2s_pkg::SLOT_BITS
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    enable_i,
    input  sample_t left_i,
    input  sample_t right_i,
    input  logic    valid_i,
    output logic    ready_o,
    output logic    bclk_o,
    output logic    lrclk_o,
    output logic    audio_data_o,
    output logic    frame_start_o,
    output logic    underrun_o
);

    localparam int unsigned PW = $clog2(SLOT_BITS);

    i2s_state_e    state_q, state_d;
    stereo_t       hold_q, hold_d;
    stereo_t       frame_q, frame_d;
    logic          full_q, full_d;
    logic          ready_q, ready_d;
    logic          audio_q, audio_d;
    logic          fs_q, fs_d;
    logic          ur_q, ur_d;
    logic          run, accept;
    logic          fall, wrap, chan;
    logic          bclk_rise_unused;
    logic [PW-1:0] pos;

    i2s_clk_gen #(
        .BCLK_HALF(BCLK_HALF),
        .SLOT_BITS(SLOT_BITS)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run),
        .bclk_o      (bclk_o),
        .lrclk_o     (lrclk_o),
        .bclk_fall_o (fall),
        .bclk_rise_o (bclk_rise_unused),
        .slot_pos_o  (pos),
        .slot_chan_o (chan),
        .frame_wrap_o(wrap)
    );

    // Dropping enable stops the clocks on the very next edge, mid-frame or not.
    assign run    = (state_q == RUN) & enable_i;
    assign accept = valid_i & ready_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable_i) state_d = RUN;
            RUN:  if (!enable_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_d  = hold_q;
        frame_d = frame_q;
        full_d  = full_q;
        audio_d = audio_q;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        if (wrap) begin
            fs_d   = 1'b1;
            full_d = 1'b0;
            if (full_q) begin
                frame_d = hold_q;
            end else begin
                frame_d = '0;
                ur_d    = 1'b1;
            end
        end
        if (accept) begin
            hold_d = '{l: left_i, r: right_i};
            full_d = 1'b1;
        end
        if (fall) begin
            audio_d = slot_bit(chan ? frame_d.r : frame_d.l, 32'(pos));
        end
        if (!run) begin
            frame_d = '0;
            audio_d = 1'b0;
        end
        ready_d = ~full_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hold_q  <= '0;
            frame_q <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            audio_q <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
            full_q  <= full_d;
            ready_q <= ready_d;
            audio_q <= audio_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    assign ready_o       = ready_q;
    assign audio_data_o  = audio_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;

endmodule
